fetch_unit: RTL and testbench

Instruction-fetch stage for the RV32I core. It sits directly upstream of the decoder/ALU/register-file datapath. It owns the PC and issues word requests to instruction memory over a valid/ready channel. Responses are buffered in a small in-order queue and presented to the decoder as an `{inst, inst_pc}` stream with valid/ready; branch/jump redirects and decoder halt are handled here.

---
 rtl/rv32_fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package rv32_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; head reads as zero when empty.
module fetch_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  T              wr_data,
  input  logic          pop,
  output T              rd_data,
  output logic [CW-1:0] count
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, issues credit-limited imem requests and
// buffers in-order responses for the decoder; handles redirect and halt.
module fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        halted
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic          active_q, active_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] tag_count, iq_count;
  logic [31:0]   tag_head;
  fetch_entry_t  iq_head, iq_wr;
  logic          running, pop, req_fire, rsp_fire;
  logic          halt_fire, redir_fire, iq_push, iq_flush;
  logic [CW:0]   in_flight;

  always_comb begin
    active_d   = 1'b1;
    running    = active_q && (state_q == RUN);
    inst_valid = running && (iq_count != '0);
    pop        = inst_valid && inst_ready;
    halt_fire  = running && halt && pop;
    redir_fire = running && redirect_valid && !halt_fire;

    // A response only moves an entry from tag queue to instruction queue, so
    // the sum is the true in-flight count; a same-cycle pop frees one credit.
    in_flight      = {1'b0, tag_count} + {1'b0, iq_count} - (CW+1)'(pop);
    imem_req_valid = running && !redirect_valid && (in_flight < CREDITS);
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_fire       = imem_rsp_valid && (tag_count != '0);

    iq_flush = halt_fire || redir_fire;
    iq_push  = running && rsp_fire && (discard_q == '0);
    iq_wr    = '{pc: tag_head, inst: imem_rsp_data};

    state_d = halt_fire ? HALTED : state_q;

    pc_d = pc_q;
    if (redir_fire)    pc_d = redirect_pc & 32'hFFFF_FFFC;
    else if (req_fire) pc_d = pc_q + 32'd4;

    discard_d = discard_q;
    if (rsp_fire && (discard_q != '0)) discard_d = discard_q - CW'(1);
    // Everything still outstanding after this cycle's response belongs to the old path.
    if (redir_fire) discard_d = tag_count - CW'(rsp_fire);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      active_q  <= 1'b0;
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_fifo #(
    .T     (logic [31:0]),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .rst_n   (rst),
    .flush   (1'b0),
    .push    (req_fire),
    .wr_data (pc_q),
    .pop     (rsp_fire),
    .rd_data (tag_head),
    .count   (tag_count)
  );

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .clk     (clk),
    .rst_n   (rst),
    .flush   (iq_flush),
    .push    (iq_push),
    .wr_data (iq_wr),
    .pop     (pop),
    .rd_data (iq_head),
    .count   (iq_count)
  );

  assign imem_req_addr = pc_q;
  assign inst          = iq_head.inst;
  assign inst_pc       = iq_head.pc;
  assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against an epoch-tagged transaction model.
module tb_fetch_unit;

  localparam logic [31:0] RPC   = 32'h0100_0000;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        halt           = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready     = 1'b1;
  logic        halted;

  fetch_unit #(
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int          due;
  } mreq_t;

  mreq_t       mq[$];      // requests accepted by memory, oldest first
  logic [31:0] exp_q[$];   // PCs the decoder should see next, in order
  int unsigned epoch;
  logic [31:0] req_pc;
  bit          halted_m;
  int          cyc;
  int          lat_min = 1, lat_max = 1;
  bit          auto_halt, rand_halt;
  logic [31:0] halt_addr = 32'h1;
  int          n_checks = 0, n_errors = 0;

  logic        s_req_hs, s_inst_valid, s_pop, s_halted;
  logic [31:0] s_req_addr, s_inst_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == halt_addr) ? 32'h0000_0073 : (a ^ KEY);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    bit    exp_valid, exp_req, pop, req_hs, halt_fire;
    mreq_t e;
    int    due;
    halt = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    #1;
    exp_valid = !halted_m && (exp_q.size() > 0);
    pop       = exp_valid && inst_ready;
    exp_req   = !halted_m && !redirect_valid &&
                ((int'(mq.size()) + int'(exp_q.size()) - (pop ? 1 : 0)) < int'(DEPTH));
    check_eq("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (!halted_m) check_eq("req_addr", imem_req_addr, req_pc);
    check_eq("inst_valid", 32'(inst_valid), 32'(exp_valid));
    check_eq("halted", 32'(halted), 32'(halted_m));
    if (exp_valid) begin
      check_eq("inst_pc", inst_pc, exp_q[0]);
      check_eq("inst", inst, mem_word(exp_q[0]));
    end
    s_req_hs     = imem_req_valid && imem_req_ready;
    s_req_addr   = imem_req_addr;
    s_inst_valid = inst_valid;
    s_pop        = inst_valid && inst_ready;
    s_inst_pc    = inst_pc;
    s_halted     = halted;

    if (auto_halt && exp_valid && mem_word(exp_q[0]) == 32'h0000_0073) halt = 1'b1;
    if (rand_halt && $urandom_range(0, 99) < 2) halt = 1'b1;
    halt_fire = halt && pop && !halted_m;
    req_hs    = exp_req && imem_req_ready;

    if (pop) void'(exp_q.pop_front());
    if (imem_rsp_valid) begin
      e = mq.pop_front();
      if (e.epoch == epoch && !halted_m) exp_q.push_back(e.addr);
    end
    if (req_hs) begin
      due = cyc + int'($urandom_range(lat_min, lat_max));
      if (mq.size() > 0 && mq[$].due > due) due = mq[$].due;
      mq.push_back('{req_pc, epoch, due});
      req_pc = req_pc + 32'd4;
    end
    if (halt_fire) begin
      halted_m = 1'b1;
      exp_q.delete();
    end else if (redirect_valid && !halted_m) begin
      exp_q.delete();
      epoch++;
      req_pc = redirect_pc & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    imem_rsp_valid = 1'b0;
    #2;
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_req_addr", imem_req_addr, RPC);
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_inst_pc", inst_pc, 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    mq.delete();
    exp_q.delete();
    epoch = 0; req_pc = RPC; halted_m = 1'b0;
    auto_halt = 1'b0; rand_halt = 1'b0; halt_addr = 32'h1;
    lat_min = 1; lat_max = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_eq("release_req_valid", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cnt;
    bit          found;
    logic [31:0] got_pcs[$];

    #3;
    // reset release, 1-cycle memory, full throughput
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      if (c < 3) begin
        check_eq("t1_req_hs", 32'(s_req_hs), 32'd1);
        check_eq("t1_req_addr", s_req_addr, RPC + 32'(4 * c));
      end
      check_eq("t1_inst_valid", 32'(s_inst_valid), (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) check_eq("t1_inst_pc", s_inst_pc, RPC + 32'(4 * (c - 2)));
    end

    // decoder backpressure: credits cap issue at DEPTH
    do_reset();
    inst_ready = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (s_req_hs) cnt++;
    end
    check_eq("t2_req_count", 32'(cnt), 32'd4);
    inst_ready = 1'b1;
    got_pcs.delete();
    for (int c = 0; c < 12; c++) begin
      step();
      if (s_pop) got_pcs.push_back(s_inst_pc);
    end
    for (int i = 0; i < 4; i++)
      check_eq("t2_drain_pc", (got_pcs.size() > i) ? got_pcs[i] : 32'hDEAD_BEEF, RPC + 32'(4 * i));

    // redirect with two stale responses in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0203;
    step();
    check_eq("t3_no_req_in_redirect", 32'(s_req_hs), 32'd0);
    redirect_valid = 1'b0;
    step();
    check_eq("t3_target_addr", s_req_addr, 32'h0100_0200);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (s_inst_valid) begin
        found = 1'b1;
        check_eq("t3_first_pc", s_inst_pc, 32'h0100_0200);
      end
    end
    check_eq("t3_delivered", 32'(found), 32'd1);

    // halt on the third instruction; redirect pulses afterwards are ignored
    do_reset();
    halt_addr = RPC + 32'd8;
    auto_halt = 1'b1;
    for (int c = 0; c < 30 && !halted_m; c++) step();
    step();
    check_eq("t4_halted", 32'(s_halted), 32'd1);
    check_eq("t4_inst_valid", 32'(s_inst_valid), 32'd0);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      redirect_valid = c[0];
      redirect_pc    = 32'h0000_4000;
      step();
      if (s_req_hs) cnt++;
    end
    redirect_valid = 1'b0;
    check_eq("t4_reqs_after_halt", 32'(cnt), 32'd0);

    // asynchronous reset with three requests outstanding
    do_reset();
    lat_min = 4; lat_max = 4;
    for (int c = 0; c < 10 && mq.size() < 3; c++) step();
    do_reset();
    step();
    check_eq("t5_restart_addr", s_req_addr, RPC);
    check_eq("t5_restart_hs", 32'(s_req_hs), 32'd1);

    // PC wrap at the top of the address space
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("t6_wrap_hs", 32'(s_req_hs), 32'd1);
      check_eq("t6_wrap_addr", s_req_addr, 32'hFFFF_FFF8 + 32'(4 * c));
    end

    // randomised traffic; the last round also fires random halts
    for (int r = 0; r < 4; r++) begin
      do_reset();
      lat_min = 1; lat_max = 4;
      rand_halt = (r == 3);
      for (int n = 0; n < 700; n++) begin
        imem_req_ready = ($urandom_range(0, 3) != 0);
        inst_ready     = ($urandom_range(0, 9) < 7);
        redirect_valid = ($urandom_range(0, 99) < 3);
        redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
        step();
      end
      redirect_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
